multicycle_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer for the SimpleRISC core. Steps each instruction through

---
 rtl/multicycle_sequencer_pkg.sv | 43 ++++
 rtl/multicycle_sequencer.sv | 171 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the SimpleRISC multi-cycle sequencer: opcodes, FSM states,
// PC source selects and fault codes.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StFault  = 3'd6
  } state_e;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_LW   = 5'h03;
  localparam logic [4:0] OP_SW   = 5'h04;
  localparam logic [4:0] OP_BEQ  = 5'h05;
  localparam logic [4:0] OP_JUMP = 5'h06;
  localparam logic [4:0] OP_RET  = 5'h07;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RET    = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= OP_RET;
  endfunction

  // Opcodes that need the ALU phase; the rest complete in DECODE.
  function automatic logic op_needs_exec(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake, retire counter
// and sticky illegal-opcode / memory-timeout trapping.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             alu_en,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             busy,
  output logic [1:0]       fault,
  output logic [2:0]       state_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [1:0]         fault_q, fault_d;
  logic [4:0]         op_q;
  logic [WaitW-1:0]   wait_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout;

  assign timeout = mem_req && !mem_ready && (wait_q == WaitLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Wait counter restarts whenever a request completes or is abandoned, so each
  // FETCH/MEM entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == StDecode) op_q <= opcode;
      if (mem_req && !mem_ready && !timeout) wait_q <= wait_q + WaitW'(1);
      else wait_q <= '0;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else if (timeout) begin
          state_d = StFault;
          fault_d = FAULT_TIMEOUT;
        end
      end
      StDecode: begin
        if (!op_is_legal(opcode)) begin
          state_d = StFault;
          fault_d = FAULT_ILLEGAL;
        end else if (op_needs_exec(opcode)) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q == OP_ADD || op_q == OP_SUB) state_d = StWb;
        else if (op_q == OP_LW || op_q == OP_SW) state_d = StMem;
      end
      StMem: begin
        if (mem_ready && op_q == OP_LW) state_d = StWb;
        else if (timeout) begin
          state_d = StFault;
          fault_d = FAULT_TIMEOUT;
        end
      end
      StWb:    state_d = state_q;
      StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase
    if (retire) state_d = halt_req ? StIdle : StFetch;
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    alu_en       = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    retire       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      StDecode: begin
        case (opcode)
          OP_NOP: begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          OP_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
          end
          OP_RET: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RET;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      StExec: begin
        alu_en = 1'b1;
        if (op_q == OP_BEQ) begin
          pc_write = 1'b1;
          pc_src   = alu_zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
          retire   = 1'b1;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        if (mem_ready && op_q == OP_SW) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired_cnt = cnt_q;
  assign busy        = (state_q != StIdle) && (state_q != StFault);
  assign fault       = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: driver pushes expected retire behaviour from a
// table-level model, a negedge monitor pops and compares on every retire pulse.
module tb_multicycle_sequencer;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic [4:0]       opcode = 5'h00;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, ir_write, alu_en, reg_write, pc_write;
  logic [1:0]       pc_src;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             busy;
  logic [1:0]       fault;
  logic [2:0]       state_o;

  multicycle_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_write    (ir_write),
    .alu_en      (alu_en),
    .reg_write   (reg_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .busy        (busy),
    .fault       (fault),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       we;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retire behaviour from the instruction table: base latency plus memory wait cycles.
  function automatic exp_t model(input int op, input int fw, input int mw, input logic z);
    exp_t e;
    logic uses_mem;
    e.op = op; e.pc_src = 2'b00; e.reg_write = 1'b0; e.we = 1'b0; uses_mem = 1'b0;
    case (op)
      1, 2:    begin e.lat = 4; e.reg_write = 1'b1; end
      3:       begin e.lat = 5; e.reg_write = 1'b1; uses_mem = 1'b1; end
      4:       begin e.lat = 4; e.we = 1'b1; uses_mem = 1'b1; end
      5:       begin e.lat = 3; e.pc_src = z ? 2'b01 : 2'b00; end
      6:       begin e.lat = 2; e.pc_src = 2'b10; end
      7:       begin e.lat = 2; e.pc_src = 2'b11; end
      default: e.lat = 2;
    endcase
    e.lat = e.lat + fw + (uses_mem ? mw : 0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Answers one memory request after `waits` stall cycles, checking the request is held.
  task automatic mem_phase(input int waits, input logic sel, input logic we);
    int guard = 0;
    while (mem_req !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      check("mem_req_appears", mem_req, 1);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      #1;
      check("mem_req_held", mem_req, 1);
      check("mem_addr_sel", mem_addr_sel, sel);
      check("mem_we_stable", mem_we, we);
      if (!sel) check("ir_write", ir_write, (i == waits));
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input int op, input int fw, input int mw, input logic z,
                           input logic halt);
    exp_t e;
    int target;
    int guard = 0;
    e = model(op, fw, mw, z);
    opcode   = 5'(op);
    alu_zero = z;
    halt_req = halt;
    sb.push_back(e);
    target = seen + 1;
    mem_phase(fw, 1'b0, 1'b0);
    if (op == 3 || op == 4) mem_phase(mw, 1'b1, (op == 4));
    while (seen < target && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("retire_seen", 32'(seen), 32'(target));
    halt_req = 1'b0;
    if (halt) begin
      check("halt_busy", busy, 0);
      check("halt_state", state_o, 0);
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  // Monitor: per-instruction latency measured from the first FETCH cycle.
  initial begin
    int   cyc = 0, fetch_start = 0, pcw = 0, mon_cnt = 0;
    logic prev_busy = 1'b0, prev_retire = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; prev_retire = 1'b0; mon_cnt = 0; pcw = 0;
      end else begin
        cyc++;
        if (busy && (!prev_busy || prev_retire)) begin
          fetch_start = cyc;
          pcw = 0;
        end
        if (pc_write) pcw++;
        if (mem_req && mem_addr_sel && sb.size() > 0) check("mem_we_vs_op", mem_we, sb[0].we);
        if (reg_write && !retire) begin
          n_vec++; n_fail++;
          $display("FAIL reg_write_without_retire: got 1 expected 0 at %0t", $time);
        end
        if (retire) begin
          if (sb.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("pc_src", pc_src, e.pc_src);
            check("reg_write", reg_write, e.reg_write);
            check("latency", 32'(cyc - fetch_start + 1), 32'(e.lat));
            check("pc_write_count", 32'(pcw), 1);
            check("retired_cnt", retired_cnt, 32'(mon_cnt));
          end
          mon_cnt++;
          seen++;
        end
        prev_busy   = busy;
        prev_retire = retire;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int op, fw, mw;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc_write", pc_write, 0);
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);

    // Zero-wait ADD, SUB, LW, SW, BEQ
    run_instr(1, 0, 0, 1'b0, 1'b0);
    run_instr(2, 0, 0, 1'b0, 1'b0);
    run_instr(3, 0, 0, 1'b0, 1'b0);
    run_instr(4, 0, 0, 1'b0, 1'b0);
    run_instr(5, 0, 0, 1'b0, 1'b0);
    check("cnt_after_5", retired_cnt, 5);

    run_instr(5, 0, 0, 1'b1, 1'b0);
    run_instr(5, 0, 0, 1'b0, 1'b0);
    run_instr(6, 0, 0, 1'b0, 1'b0);
    run_instr(7, 0, 0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 1'b0, 1'b0);
    run_instr(3, 0, 3, 1'b0, 1'b0);
    run_instr(1, 0, 0, 1'b0, 1'b1);

    repeat (60) begin
      op = int'($urandom_range(0, 7));
      fw = int'($urandom_range(0, 4));
      mw = int'($urandom_range(0, 4));
      run_instr(op, fw, mw, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Fetch never answered: timeout after MEM_TIMEOUT request cycles.
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      check("timeout_req_held", mem_req, 1);
      step();
    end
    check("timeout_state", state_o, 6);
    check("timeout_fault", fault, 2'b10);
    check("timeout_req_drop", mem_req, 0);
    check("timeout_busy", busy, 0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("fault_ignores_start", state_o, 6);
    check("fault_sticky", fault, 2'b10);

    rst_n = 1'b0;
    #1;
    check("rst_clears_fault", fault, 0);
    check("rst_to_idle", state_o, 0);
    step();
    rst_n = 1'b1;

    // Illegal opcode in DECODE.
    start = 1'b1;
    step();
    start = 1'b0;
    opcode = 5'h1F;
    mem_phase(0, 1'b0, 1'b0);
    check("illegal_decode_state", state_o, 2);
    check("illegal_no_pc_write", pc_write, 0);
    check("illegal_no_reg_write", reg_write, 0);
    step();
    check("illegal_fault", fault, 2'b01);
    check("illegal_state", state_o, 6);
    check("illegal_busy", busy, 0);
    rst_n = 1'b0;
    #1;
    check("illegal_rst_fault", fault, 0);
    step();
    rst_n = 1'b1;

    // Reset asserted while a load waits in MEM.
    start = 1'b1;
    step();
    start = 1'b0;
    opcode = 5'h03;
    mem_phase(0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) step();
    check("mid_mem_req", mem_req, 1);
    check("mid_mem_sel", mem_addr_sel, 1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_mem_req", mem_req, 0);
    check("rst_mid_state", state_o, 0);
    step();
    rst_n = 1'b1;
    step();
    check("queue_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
